// File: rtl/fei4_cmd_tx_pkg.sv
// FE-I4 command transmitter shared definitions.
// Register addresses, FSM states and the config bundle.
package fei4_cmd_tx_pkg;

  localparam logic [15:0] ADDR_RST      = 16'd0;
  localparam logic [15:0] ADDR_START    = 16'd1;
  localparam logic [15:0] ADDR_SIZE_L   = 16'd2;
  localparam logic [15:0] ADDR_SIZE_H   = 16'd3;
  localparam logic [15:0] ADDR_REP_L    = 16'd4;
  localparam logic [15:0] ADDR_REP_H    = 16'd5;
  localparam logic [15:0] ADDR_GAP      = 16'd6;
  localparam logic [15:0] ADDR_EXT      = 16'd7;
  localparam logic [15:0] ADDR_MEM_BASE = 16'd16;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP,
    FIN
  } state_t;

  typedef struct packed {
    logic [15:0] size;
    logic [15:0] rep;
    logic [7:0]  gap;
  } cfg_t;

  function automatic logic pick_bit(
    input logic [7:0] b,
    input logic [2:0] k
  );
    return b[3'd7 - k];
  endfunction

endpackage

// File: rtl/fei4_cmd_tx_core.sv
// FE-I4 command serializer: FSM, bit/repeat/divider counters.
// Expects cfg.size already clipped and cfg.rep already >= 1.
module fei4_cmd_tx_core
  import fei4_cmd_tx_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int AW      = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          soft_rst,
  input  cfg_t          cfg,
  output logic [AW-1:0] mem_addr,
  input  logic [7:0]    mem_rdata,
  output logic          cmd_data,
  output logic          start_flag,
  output logic          busy,
  output logic          done
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_t      state, state_n;
  logic [15:0] bit_cnt, bit_n;
  logic [15:0] rep_cnt, rep_n;
  logic [7:0]  div_cnt, div_n;
  logic        data_n, flag_n, done_n;

  logic [15:0] rd_idx;
  logic        rd_bit;
  logic        last_div;
  logic        last_bit;
  logic        last_gap;
  logic        more_rep;

  assign last_div = div_cnt == DIV_LAST;
  assign last_bit = bit_cnt == cfg.size - 16'd1;
  assign last_gap = bit_cnt == {8'd0, cfg.gap} - 16'd1;
  assign more_rep = rep_cnt < cfg.rep;

  // Look-ahead read: the bit that gets registered onto cmd_data next.
  assign rd_idx = (state == SEND && !last_bit)
                ? bit_cnt + 16'd1 : 16'd0;
  assign mem_addr = AW'(rd_idx >> 3);
  assign rd_bit = pick_bit(mem_rdata, rd_idx[2:0]);

  assign busy = (state == SEND) || (state == GAP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      rep_cnt    <= '0;
      div_cnt    <= '0;
      cmd_data   <= 1'b0;
      start_flag <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      bit_cnt    <= bit_n;
      rep_cnt    <= rep_n;
      div_cnt    <= div_n;
      cmd_data   <= data_n;
      start_flag <= flag_n;
      done       <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    bit_n   = bit_cnt;
    rep_n   = rep_cnt;
    div_n   = div_cnt;
    data_n  = cmd_data;
    flag_n  = 1'b0;
    done_n  = done;
    unique case (state)
      IDLE: begin
        data_n = 1'b0;
        if (start) begin
          done_n = 1'b0;
          if (cfg.size == 16'd0) begin
            state_n = FIN;
          end else begin
            state_n = SEND;
            bit_n   = '0;
            rep_n   = 16'd1;
            div_n   = '0;
            data_n  = rd_bit;
            flag_n  = 1'b1;
          end
        end
      end
      SEND: begin
        if (!last_div) begin
          div_n = div_cnt + 8'd1;
        end else begin
          div_n = '0;
          if (!last_bit) begin
            bit_n  = bit_cnt + 16'd1;
            data_n = rd_bit;
          end else if (more_rep && cfg.gap != 8'd0) begin
            state_n = GAP;
            bit_n   = '0;
            data_n  = 1'b0;
          end else if (more_rep) begin
            bit_n  = '0;
            rep_n  = rep_cnt + 16'd1;
            data_n = rd_bit;
          end else begin
            state_n = FIN;
            data_n  = 1'b0;
          end
        end
      end
      GAP: begin
        data_n = 1'b0;
        if (!last_div) begin
          div_n = div_cnt + 8'd1;
        end else begin
          div_n = '0;
          if (last_gap) begin
            state_n = SEND;
            bit_n   = '0;
            rep_n   = rep_cnt + 16'd1;
            data_n  = rd_bit;
          end else begin
            bit_n = bit_cnt + 16'd1;
          end
        end
      end
      FIN: begin
        state_n = IDLE;
        data_n  = 1'b0;
        done_n  = 1'b1;
      end
      default: state_n = IDLE;
    endcase
    if (soft_rst) begin
      state_n = IDLE;
      data_n  = 1'b0;
      flag_n  = 1'b0;
      done_n  = 1'b0;
    end
  end

endmodule

// File: rtl/fei4_cmd_tx.sv
// FE-I4 command transmitter: register file, byte buffer, bus decode.
// FEI4_CMD_TX_EXT_TRIG_EN adds EXT_START and the EXT_EN register.
module fei4_cmd_tx
  import fei4_cmd_tx_pkg::*;
#(
  parameter int MEM_BYTES = 16,
  parameter int CLK_DIV   = 4
) (
  input  logic        BUS_CLK,
  input  logic        BUS_RST_N,
  input  logic [15:0] BUS_ADD,
  input  logic [7:0]  BUS_DATA_IN,
  output logic [7:0]  BUS_DATA_OUT,
  input  logic        BUS_WR,
  input  logic        BUS_RD,
`ifdef FEI4_CMD_TX_EXT_TRIG_EN
  input  logic        EXT_START,
`endif
  output logic        CMD_DATA,
  output logic        CMD_READY,
  output logic        CMD_START_FLAG
);

  localparam int AW = $clog2(MEM_BYTES);
  localparam logic [15:0] MEM_BITS = 16'(MEM_BYTES * 8);
  localparam logic [15:0] MEM_END  = 16'(16 + MEM_BYTES);

  logic [7:0]    mem [MEM_BYTES];
  logic [15:0]   size_r;
  logic [15:0]   rep_r;
  logic [7:0]    gap_r;
  logic          mem_hit;
  logic [AW-1:0] mem_off;
  logic [AW-1:0] core_addr;
  logic          bus_start;
  logic          soft_rst;
  logic          ext_start;
  logic          busy;
  logic          done;
  logic          unused_rd;
  cfg_t          cfg;

  assign unused_rd = BUS_RD;

  assign mem_hit = (BUS_ADD >= ADDR_MEM_BASE) && (BUS_ADD < MEM_END);
  assign mem_off = AW'(BUS_ADD - ADDR_MEM_BASE);
  assign bus_start = BUS_WR && BUS_ADD == ADDR_START;
  assign soft_rst  = BUS_WR && BUS_ADD == ADDR_RST;

  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) begin
      size_r <= '0;
      rep_r  <= 16'd1;
      gap_r  <= '0;
    end else if (BUS_WR) begin
      unique case (BUS_ADD)
        ADDR_SIZE_L: size_r[7:0]  <= BUS_DATA_IN;
        ADDR_SIZE_H: size_r[15:8] <= BUS_DATA_IN;
        ADDR_REP_L:  rep_r[7:0]   <= BUS_DATA_IN;
        ADDR_REP_H:  rep_r[15:8]  <= BUS_DATA_IN;
        ADDR_GAP:    gap_r        <= BUS_DATA_IN;
        default: ;
      endcase
    end
  end

  // Buffer contents survive both resets.
  always_ff @(posedge BUS_CLK) begin
    if (BUS_WR && mem_hit)
      mem[mem_off] <= BUS_DATA_IN;
  end

`ifdef FEI4_CMD_TX_EXT_TRIG_EN
  logic ext_en;
  logic ext_q;

  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) begin
      ext_en <= 1'b0;
      ext_q  <= 1'b0;
    end else begin
      ext_q <= EXT_START;
      if (BUS_WR && BUS_ADD == ADDR_EXT)
        ext_en <= BUS_DATA_IN[0];
    end
  end

  assign ext_start = EXT_START && !ext_q && ext_en;
`else
  assign ext_start = 1'b0;
`endif

  assign cfg.size = (size_r > MEM_BITS) ? MEM_BITS : size_r;
  assign cfg.rep  = (rep_r == 16'd0) ? 16'd1 : rep_r;
  assign cfg.gap  = gap_r;

  fei4_cmd_tx_core #(
    .CLK_DIV (CLK_DIV),
    .AW      (AW)
  ) u_core (
    .clk        (BUS_CLK),
    .rst_n      (BUS_RST_N),
    .start      (bus_start || ext_start),
    .soft_rst   (soft_rst),
    .cfg        (cfg),
    .mem_addr   (core_addr),
    .mem_rdata  (mem[core_addr]),
    .cmd_data   (CMD_DATA),
    .start_flag (CMD_START_FLAG),
    .busy       (busy),
    .done       (done)
  );

  assign CMD_READY = !busy;

  always_comb begin
    BUS_DATA_OUT = '0;
    unique case (1'b1)
      BUS_ADD == ADDR_START:  BUS_DATA_OUT = {6'b0, done, busy};
      BUS_ADD == ADDR_SIZE_L: BUS_DATA_OUT = size_r[7:0];
      BUS_ADD == ADDR_SIZE_H: BUS_DATA_OUT = size_r[15:8];
      BUS_ADD == ADDR_REP_L:  BUS_DATA_OUT = rep_r[7:0];
      BUS_ADD == ADDR_REP_H:  BUS_DATA_OUT = rep_r[15:8];
      BUS_ADD == ADDR_GAP:    BUS_DATA_OUT = gap_r;
`ifdef FEI4_CMD_TX_EXT_TRIG_EN
      BUS_ADD == ADDR_EXT:    BUS_DATA_OUT = {7'b0, ext_en};
`endif
      mem_hit:                BUS_DATA_OUT = mem[mem_off];
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fei4_cmd_tx.sv
// Scoreboard bench for fei4_cmd_tx: expected per-cycle CMD stream
// is queued by stimulus and popped by a negedge monitor.
module tb_fei4_cmd_tx;

  localparam int DIV = 4;
  localparam int NB  = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [15:0] bus_add = '0;
  logic [7:0] bus_din = '0;
  logic [7:0] bus_dout;
  logic       bus_wr = 1'b0;
  logic       bus_rd = 1'b0;
  logic       cmd_data;
  logic       cmd_ready;
  logic       start_flag;
`ifdef FEI4_CMD_TX_EXT_TRIG_EN
  logic       ext_start = 1'b0;
`endif

  int total = 0;
  int bad = 0;
  logic [1:0] exp_q[$];
  logic [7:0] model_mem[NB];

  always #5 clk = ~clk;

  fei4_cmd_tx #(
    .MEM_BYTES (NB),
    .CLK_DIV   (DIV)
  ) dut (
    .BUS_CLK        (clk),
    .BUS_RST_N      (rst_n),
    .BUS_ADD        (bus_add),
    .BUS_DATA_IN    (bus_din),
    .BUS_DATA_OUT   (bus_dout),
    .BUS_WR         (bus_wr),
    .BUS_RD         (bus_rd),
`ifdef FEI4_CMD_TX_EXT_TRIG_EN
    .EXT_START      (ext_start),
`endif
    .CMD_DATA       (cmd_data),
    .CMD_READY      (cmd_ready),
    .CMD_START_FLAG (start_flag)
  );

  // Monitor: every busy cycle consumes one expected {flag,data} entry.
  always @(negedge clk) begin
    logic [1:0] e;
    if (!cmd_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL extra_busy t=%0t got flag/data=%b%b req=none",
                 $time, start_flag, cmd_data);
      end else begin
        e = exp_q.pop_front();
        if ({start_flag, cmd_data} !== e) begin
          bad++;
          $display("FAIL stream t=%0t got flag/data=%b%b req=%b",
                   $time, start_flag, cmd_data, e);
        end
      end
    end else if (rst_n) begin
      total++;
      if ({start_flag, cmd_data} !== 2'b00) begin
        bad++;
        $display("FAIL idle_out t=%0t got flag/data=%b%b req=00",
                 $time, start_flag, cmd_data);
      end
    end
  end

  task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
    @(posedge clk);
    #1;
    bus_add = a;
    bus_din = d;
    bus_wr  = 1'b1;
    @(posedge clk);
    #1;
    bus_wr = 1'b0;
  endtask

  task automatic mem_write(input int i, input logic [7:0] d);
    model_mem[i] = d;
    bus_write(16'(16 + i), d);
  endtask

  task automatic check_read(input logic [15:0] a, input logic [7:0] x,
                            input string name);
    bus_add = a;
    #1;
    total++;
    if (bus_dout !== x) begin
      bad++;
      $display("FAIL %s got=%02h req=%02h", name, bus_dout, x);
    end
  endtask

  function automatic logic exp_bit(input int k);
    logic [7:0] b;
    b = model_mem[k >> 3];
    return b[7 - (k & 7)];
  endfunction

  task automatic push_stream(input int nbits, input int reps,
                             input int gap, input int limit);
    int n = 0;
    for (int r = 0; r < reps; r++) begin
      for (int k = 0; k < nbits; k++)
        for (int c = 0; c < DIV; c++) begin
          if (n < limit)
            exp_q.push_back({(r == 0 && k == 0 && c == 0), exp_bit(k)});
          n++;
        end
      if (r < reps - 1)
        for (int g = 0; g < gap * DIV; g++) begin
          if (n < limit) exp_q.push_back(2'b00);
          n++;
        end
    end
  endtask

  // Waits until the stream is consumed and the DUT is out of SEND/GAP,
  // then checks the FIN cycle (DONE not yet set) and the cycle after.
  task automatic wait_done(input int limit, input string name);
    int i;
    for (i = 0; i < limit; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && cmd_ready) break;
    end
    total++;
    if (i >= limit) begin
      bad++;
      $display("FAIL %s_timeout got left=%0d req=0", name, exp_q.size());
      exp_q.delete();
    end
    check_read(16'd1, 8'h00, {name, "_fin"});
    @(posedge clk);
    #1;
    check_read(16'd1, 8'h02, {name, "_done"});
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (cmd_data !== 1'b0 || cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_pins got data=%b ready=%b req data=0 ready=1",
               cmd_data, cmd_ready);
    end
    rst_n = 1'b1;
    check_read(16'd1, 8'h00, "reset_status");
    check_read(16'd4, 8'h01, "reset_rep_l");
    check_read(16'd2, 8'h00, "reset_size_l");
    check_read(16'd8, 8'h00, "unmapped_8");
    check_read(16'd32, 8'h00, "unmapped_mem_end");

    // Single byte 0xB1, 8 bits, one repetition
    mem_write(0, 8'hB1);
    bus_write(16'd2, 8'd8);
    check_read(16'd16, 8'hB1, "mem_rb");
    push_stream(8, 1, 0, 1 << 20);
    bus_write(16'd1, 8'h01);
    wait_done(100, "b1");

    // 12 bits, 3 repetitions, 2-bit gaps
    mem_write(0, 8'hFF);
    mem_write(1, 8'h00);
    bus_write(16'd2, 8'd12);
    bus_write(16'd4, 8'd3);
    bus_write(16'd6, 8'd2);
    push_stream(12, 3, 2, 1 << 20);
    bus_write(16'd1, 8'h01);
    wait_done(300, "rep3");

    // Zero size goes straight to FIN
    bus_write(16'd2, 8'd0);
    bus_write(16'd1, 8'h01);
    check_read(16'd1, 8'h00, "size0_fin");
    @(posedge clk);
    #1;
    check_read(16'd1, 8'h02, "size0_done");

    // Abort in bit 5 of 16, then restart from bit 0
    mem_write(0, 8'hA5);
    mem_write(1, 8'h3C);
    bus_write(16'd2, 8'd16);
    bus_write(16'd4, 8'd1);
    bus_write(16'd6, 8'd0);
    push_stream(16, 1, 0, 21);
    bus_write(16'd1, 8'h01);
    repeat (19) @(posedge clk);
    bus_write(16'd0, 8'h00);
    check_read(16'd1, 8'h00, "softrst_status");
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL softrst_left got=%0d req=0", exp_q.size());
      exp_q.delete();
    end
    check_read(16'd2, 8'd16, "softrst_size_kept");
    push_stream(16, 1, 0, 1 << 20);
    bus_write(16'd1, 8'h01);
    wait_done(200, "restart");

    // Second start while busy is ignored
    push_stream(16, 1, 0, 1 << 20);
    bus_write(16'd1, 8'h01);
    repeat (8) @(posedge clk);
    bus_write(16'd1, 8'h01);
    wait_done(200, "dblstart");

    // SIZE above buffer capacity clips to 128 bits, REPEAT=0 acts as 1
    for (int i = 0; i < NB; i++) mem_write(i, 8'((i * 37 + 11) ^ 8'h5A));
    bus_write(16'd2, 8'h00);
    bus_write(16'd3, 8'h01);
    bus_write(16'd4, 8'h00);
    bus_write(16'd6, 8'd5);
    check_read(16'd3, 8'h01, "size_h_rb");
    check_read(16'd6, 8'd5, "gap_rb");
    check_read(16'd21, model_mem[5], "mem5_rb");
    push_stream(NB * 8, 1, 5, 1 << 20);
    bus_write(16'd1, 8'h01);
    wait_done(700, "clip");

`ifdef FEI4_CMD_TX_EXT_TRIG_EN
    bus_write(16'd2, 8'd16);
    bus_write(16'd3, 8'd0);
    check_read(16'd7, 8'h00, "ext_en_reset");
    @(posedge clk);
    #1;
    ext_start = 1'b1;
    @(posedge clk);
    #1;
    ext_start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check_read(16'd1, 8'h02, "ext_disabled");
    bus_write(16'd7, 8'h01);
    check_read(16'd7, 8'h01, "ext_en_rb");
    push_stream(16, 1, 0, 1 << 20);
    @(posedge clk);
    #1;
    ext_start = 1'b1;
    @(posedge clk);
    #1;
    ext_start = 1'b0;
    wait_done(200, "ext");
`else
    bus_write(16'd7, 8'h01);
    check_read(16'd7, 8'h00, "ext_absent");
`endif

    repeat (5) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
